// File: rtl/fifo_word_unpacker.sv
// Drain stage behind the synchronous word FIFO: reads WIDTH-bit words and
// streams them out as OUT_WIDTH slices, LS slice first, with a 2-word prefetch.
module fifo_word_unpacker #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_rd_en,
    input  logic                 flush,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);
    localparam int RATIO = WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [WIDTH-1:0] cur, nxt;
    logic [1:0]       occ;
    logic             inflight;
    logic [IDX_W-1:0] idx;
    logic             xfer, pop_word;
    logic [2:0]       credit;

    always_comb begin
        out_valid = (occ != 2'd0);
        xfer      = out_valid && out_ready;
        pop_word  = xfer && (idx == LAST_IDX);
        // A word leaving this cycle frees its slot, so RATIO=1 can read every cycle.
        credit     = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop_word};
        fifo_rd_en = !rst && !flush && !fifo_empty && (credit < 3'd2);
        out_data   = out_valid ? cur[int'(idx)*OUT_WIDTH +: OUT_WIDTH] : '0;
        out_last   = out_valid && (idx == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            idx      <= '0;
        end else begin
            inflight <= fifo_rd_en;
            occ      <= occ - {1'b0, pop_word} + {1'b0, inflight};
            if (xfer)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            // Returning word goes to the first slot that is free after this cycle's pop.
            if (inflight) begin
                if (occ == 2'd0 || (occ == 2'd1 && pop_word)) begin
                    cur <= fifo_data;
                end else if (occ == 2'd1) begin
                    nxt <= fifo_data;
                end else begin
                    cur <= nxt;
                    nxt <= fifo_data;
                end
            end else if (pop_word) begin
                cur <= nxt;
            end
        end
    end
endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Directed bench for fifo_word_unpacker: byte-slice instance (32/8) and a
// full-width instance (32/32), each fed by a small FIFO model with 1-cycle read latency.
module tb_fifo_word_unpacker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // ---------------- instance A: 32 -> 8 ----------------
    logic        rst_a, fe_a, rd_a, flush_a, ready_a, valid_a, last_a;
    logic [31:0] fd_a;
    logic [7:0]  data_a;
    logic [31:0] mem_a [0:63];
    int          wp_a = 0, rp_a = 0, rdcnt_a = 0, outst_a = 0;
    logic [8:0]  log_a [$];
    logic        popw_a;

    assign fe_a   = (wp_a == rp_a);
    assign popw_a = valid_a && ready_a && last_a;

    fifo_word_unpacker #(.WIDTH(32), .OUT_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst_a), .fifo_empty(fe_a), .fifo_data(fd_a),
        .fifo_rd_en(rd_a), .flush(flush_a), .out_data(data_a),
        .out_valid(valid_a), .out_ready(ready_a), .out_last(last_a));

    // ---------------- instance B: 32 -> 32 ----------------
    logic        rst_b, fe_b, rd_b, flush_b, ready_b, valid_b, last_b;
    logic [31:0] fd_b, data_b;
    logic [31:0] mem_b [0:63];
    int          wp_b = 0, rp_b = 0;
    logic [31:0] logd_b [$];
    int          logc_b [$];
    logic        logl_b [$];

    assign fe_b = (wp_b == rp_b);

    fifo_word_unpacker #(.WIDTH(32), .OUT_WIDTH(32)) dut_b (
        .clk(clk), .rst(rst_b), .fifo_empty(fe_b), .fifo_data(fd_b),
        .fifo_rd_en(rd_b), .flush(flush_b), .out_data(data_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_last(last_b));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // FIFO models: registered read data, one word per accepted read
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_a) begin
            fd_a    <= mem_a[rp_a[5:0]];
            rp_a    <= rp_a + 1;
            rdcnt_a <= rdcnt_a + 1;
        end
        if (rd_b) begin
            fd_b <= mem_b[rp_b[5:0]];
            rp_b <= rp_b + 1;
        end
        // words read but not yet fully streamed out
        if (rst_a || flush_a) outst_a <= 0;
        else outst_a <= outst_a + int'(rd_a) - int'(popw_a);
    end

    always @(negedge clk) begin
        if (valid_a && ready_a && !flush_a && !rst_a)
            log_a.push_back({last_a, data_a});
        if (valid_b && ready_b && !flush_b && !rst_b) begin
            logd_b.push_back(data_b);
            logc_b.push_back(cyc);
            logl_b.push_back(last_b);
        end
        if (rd_a) begin
            chk("rd_while_empty", fe_a, 1'b0);
            chk("rd_over_credit", (outst_a - int'(popw_a)) < 2, 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_a(input logic [31:0] w);
        mem_a[wp_a[5:0]] = w;
        wp_a++;
    endtask

    task automatic push_b(input logic [31:0] w);
        mem_b[wp_b[5:0]] = w;
        wp_b++;
    endtask

    task automatic chk_log(input string tag, input int base, input int j,
                           input logic [7:0] b, input logic l);
        logic [8:0] e;
        e = log_a[base + j];
        chk(tag, e, {l, b});
    endtask

    logic [7:0] t1_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] t3_bytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] t5_bytes [4] = '{8'h18, 8'h19, 8'h1A, 8'h1B};

    initial begin
        int base, rbase;
        rst_a = 1'b1; flush_a = 1'b0; ready_a = 1'b1;
        rst_b = 1'b1; flush_b = 1'b0; ready_b = 1'b1;
        push_a(32'h4433_2211);
        tick(); tick();
        #1;
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_data", data_a, 8'h00);
        chk("rst_last", last_a, 1'b0);
        chk("rst_rd_gated", rd_a, 1'b0);

        // 1: single word, ready held high
        base = log_a.size();
        tick(); rst_a = 1'b0; #1;
        chk("t1_rd", rd_a, 1'b1);
        chk("t1_valid_n", valid_a, 1'b0);
        tick(); #1;
        chk("t1_valid_n1", valid_a, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("t1_valid", valid_a, 1'b1);
            chk("t1_data", data_a, t1_bytes[i]);
            chk("t1_last", last_a, i == 3);
        end
        tick(); #1;
        chk("t1_drained", valid_a, 1'b0);
        chk("t1_count", log_a.size() - base, 4);

        // 2: four words with ready toggling every cycle
        base = log_a.size();
        tick();
        push_a(32'h0302_0100); push_a(32'h0706_0504);
        push_a(32'h0B0A_0908); push_a(32'h0F0E_0D0C);
        for (int i = 0; i < 48; i++) begin
            ready_a = (i % 2 == 0);
            tick();
        end
        ready_a = 1'b1;
        tick(); #1;
        chk("t2_count", log_a.size() - base, 16);
        for (int j = 0; j < 16; j++)
            chk_log("t2_slice", base, j, 8'(j), (j % 4) == 3);

        // 3: long empty period, then one word
        rbase = rdcnt_a;
        for (int i = 0; i < 50; i++) tick();
        chk("t3_idle_reads", rdcnt_a - rbase, 0);
        base = log_a.size();
        push_a(32'hDDCC_BBAA);
        for (int i = 0; i < 8; i++) tick();
        chk("t3_reads", rdcnt_a - rbase, 1);
        chk("t3_count", log_a.size() - base, 4);
        for (int j = 0; j < 4; j++)
            chk_log("t3_slice", base, j, t3_bytes[j], j == 3);

        // 4: flush after slice 0x22 with the next word in flight
        base = log_a.size();
        tick(); push_a(32'h4433_2211);
        tick();
        tick(); #1;
        chk("t4_s0", data_a, 8'h11);
        tick(); push_a(32'h8877_6655); #1;
        chk("t4_s1", data_a, 8'h22);
        chk("t4_rd_next", rd_a, 1'b1);
        tick(); flush_a = 1'b1;
        tick(); flush_a = 1'b0; #1;
        chk("t4_valid", valid_a, 1'b0);
        chk("t4_data", data_a, 8'h00);
        chk("t4_last", last_a, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk("t4_count", log_a.size() - base, 2);
        chk_log("t4_slice0", base, 0, 8'h11, 1'b0);
        chk_log("t4_slice1", base, 1, 8'h22, 1'b0);

        // 5: reset mid-word with both buffer slots full
        tick(); ready_a = 1'b0;
        push_a(32'h1312_1110); push_a(32'h1716_1514); push_a(32'h1B1A_1918);
        tick(); tick();
        tick(); ready_a = 1'b1; #1;
        chk("t5_first", data_a, 8'h10);
        tick(); ready_a = 1'b0; rst_a = 1'b1;
        tick(); #1;
        chk("t5_valid", valid_a, 1'b0);
        chk("t5_data", data_a, 8'h00);
        chk("t5_last", last_a, 1'b0);
        chk("t5_rd_gated", rd_a, 1'b0);
        base = log_a.size();
        tick(); rst_a = 1'b0; ready_a = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("t5_count", log_a.size() - base, 4);
        for (int j = 0; j < 4; j++)
            chk_log("t5_slice", base, j, t5_bytes[j], j == 3);

        // 6: full-width instance, 16 back-to-back words
        tick(); rst_b = 1'b0;
        for (int i = 0; i < 16; i++) push_b(32'hB000_0000 + 32'(i));
        for (int i = 0; i < 24; i++) tick();
        chk("t6_count", logd_b.size(), 16);
        if (logd_b.size() == 16) begin
            chk("t6_span", logc_b[15] - logc_b[0], 15);
            for (int j = 0; j < 16; j++) begin
                chk("t6_data", logd_b[j], 32'hB000_0000 + 32'(j));
                chk("t6_last", logl_b[j], 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
